// File: rtl/tug_of_war_field_pkg.sv
// Shared types for the tug-of-war playfield: round winner, controller state,
// and the centre-light helper.
package tow_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } winner_t;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  function automatic int center_of(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_of_war_field_if.sv
// Playfield bus: synchronised press levels in, light/score/result outputs out.
interface tug_of_war_field_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);

  logic                  l_press;
  logic                  r_press;
  logic [NUM_LIGHTS-1:0] lights;
  logic [SCORE_W-1:0]    l_score;
  logic [SCORE_W-1:0]    r_score;
  tow_pkg::winner_t      winner;
  logic                  round_win;
  logic                  match_over;

  modport master (
    output l_press, r_press,
    input  lights, l_score, r_score, winner, round_win, match_over
  );

  modport slave (
    input  l_press, r_press,
    output lights, l_score, r_score, winner, round_win, match_over
  );

endinterface

// File: rtl/tug_of_war_field_press_edge.sv
// Rising-edge detector for one player's press level; one pull per press.
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic press,
  output logic pull
);

  logic prev;

  // History resets high so a key held through reset must be released first.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= press;
  end

  assign pull = press & ~prev;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield core: light position, round scoring, post-win hold
// and match-over freeze.
module tug_of_war_field
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int MAX_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  tug_of_war_field_if.slave bus
);

  // state      | meaning
  // PLAY       | pulls move the light; edge pulls past an end win the round
  // HOLD       | round result shown, pulls ignored until the counter expires
  // MATCH_OVER | a player reached MAX_SCORE; frozen until reset

  localparam int CENTER = center_of(NUM_LIGHTS);
  localparam int POS_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]      POS_MAX    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]      POS_CENTER = POS_W'(CENTER);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]    SCORE_MAX  = SCORE_W'(MAX_SCORE);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE  = NUM_LIGHTS'(1);

  logic l_pull, r_pull, eff_l, eff_r;

  state_t                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [SCORE_W-1:0]    l_score_q, l_score_d;
  logic [SCORE_W-1:0]    r_score_q, r_score_d;
  winner_t               winner_q, winner_d;
  logic                  round_win_q, round_win_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;

  press_edge u_l_edge (.clk(clk), .reset(reset), .press(bus.l_press), .pull(l_pull));
  press_edge u_r_edge (.clk(clk), .reset(reset), .press(bus.r_press), .pull(r_pull));

  // Simultaneous pulls cancel each other.
  assign eff_l = l_pull & ~r_pull;
  assign eff_r = r_pull & ~l_pull;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      pos_q       <= POS_CENTER;
      hold_q      <= '0;
      l_score_q   <= '0;
      r_score_q   <= '0;
      winner_q    <= NONE;
      round_win_q <= 1'b0;
      lights_q    <= LIGHT_ONE << POS_CENTER;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hold_q      <= hold_d;
      l_score_q   <= l_score_d;
      r_score_q   <= r_score_d;
      winner_q    <= winner_d;
      round_win_q <= round_win_d;
      lights_q    <= lights_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hold_d      = hold_q;
    l_score_d   = l_score_q;
    r_score_d   = r_score_q;
    winner_d    = winner_q;
    round_win_d = 1'b0;
    lights_d    = lights_q;

    case (state_q)
      PLAY: begin
        if (eff_l) begin
          if (pos_q == POS_MAX) begin
            l_score_d   = l_score_q + SCORE_W'(1);
            winner_d    = LEFT;
            round_win_d = 1'b1;
            lights_d    = '0;
            hold_d      = '0;
            state_d     = (l_score_d == SCORE_MAX) ? MATCH_OVER : HOLD;
          end else begin
            pos_d    = pos_q + POS_W'(1);
            lights_d = LIGHT_ONE << pos_d;
          end
        end else if (eff_r) begin
          if (pos_q == '0) begin
            r_score_d   = r_score_q + SCORE_W'(1);
            winner_d    = RIGHT;
            round_win_d = 1'b1;
            lights_d    = '0;
            hold_d      = '0;
            state_d     = (r_score_d == SCORE_MAX) ? MATCH_OVER : HOLD;
          end else begin
            pos_d    = pos_q - POS_W'(1);
            lights_d = LIGHT_ONE << pos_d;
          end
        end
      end

      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d  = PLAY;
          pos_d    = POS_CENTER;
          lights_d = LIGHT_ONE << POS_CENTER;
          winner_d = NONE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      MATCH_OVER: begin
        lights_d = '0;
      end

      default: begin
        state_d = PLAY;
      end
    endcase
  end

  assign bus.lights     = lights_q;
  assign bus.l_score    = l_score_q;
  assign bus.r_score    = r_score_q;
  assign bus.winner     = winner_q;
  assign bus.round_win  = round_win_q;
  assign bus.match_over = (state_q == MATCH_OVER);

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed bench for tug_of_war_field: a 9-light and a 5-light instance,
// MAX_SCORE=3, HOLD_CYCLES=4.
module tb_tug_of_war_field;
  import tow_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tug_of_war_field_if #(.NUM_LIGHTS(9), .SCORE_W(3)) if9 ();
  tug_of_war_field_if #(.NUM_LIGHTS(5), .SCORE_W(3)) if5 ();

  tug_of_war_field #(.NUM_LIGHTS(9), .MAX_SCORE(3), .SCORE_W(3), .HOLD_CYCLES(4)) dut9 (
    .clk(clk), .reset(reset), .bus(if9.slave)
  );

  tug_of_war_field #(.NUM_LIGHTS(5), .MAX_SCORE(3), .SCORE_W(3), .HOLD_CYCLES(4)) dut5 (
    .clk(clk), .reset(reset), .bus(if5.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press, check lights one edge later, release.
  task automatic tap9(input bit left, input logic [31:0] exp, input string tag);
    if (left) if9.l_press = 1'b1; else if9.r_press = 1'b1;
    step(1);
    chk(tag, 32'(if9.lights), exp);
    if9.l_press = 1'b0;
    if9.r_press = 1'b0;
    step(1);
  endtask

  task automatic tap5(input bit left, input logic [31:0] exp, input string tag);
    if (left) if5.l_press = 1'b1; else if5.r_press = 1'b1;
    step(1);
    chk(tag, 32'(if5.lights), exp);
    if5.l_press = 1'b0;
    if5.r_press = 1'b0;
    step(1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    if9.l_press = 1'b0; if9.r_press = 1'b0;
    if5.l_press = 1'b0; if5.r_press = 1'b0;
    reset = 1'b1;
    step(2);

    // Reset values
    chk("rst_lights9",  32'(if9.lights), 32'h010);
    chk("rst_lscore",   32'(if9.l_score), 32'd0);
    chk("rst_rscore",   32'(if9.r_score), 32'd0);
    chk("rst_winner",   32'(if9.winner), 32'd0);
    chk("rst_roundwin", 32'(if9.round_win), 32'd0);
    chk("rst_matchover",32'(if9.match_over), 32'd0);
    chk("rst_lights5",  32'(if5.lights), 32'h04);
    reset = 1'b0;
    step(1);
    chk("idle_lights9", 32'(if9.lights), 32'h010);

    // Scenario 1: three right pulls
    tap9(1'b0, 32'h008, "s1_r1");
    tap9(1'b0, 32'h004, "s1_r2");
    tap9(1'b0, 32'h002, "s1_r3");
    chk("s1_rscore", 32'(if9.r_score), 32'd0);
    chk("s1_lscore", 32'(if9.l_score), 32'd0);

    // Scenario 2: held press moves once; simultaneous pulls cancel
    pulse_reset();
    if9.l_press = 1'b1;
    step(1);
    chk("s2_first_move", 32'(if9.lights), 32'h020);
    step(19);
    chk("s2_no_repeat", 32'(if9.lights), 32'h020);
    if9.l_press = 1'b0;
    step(1);
    if9.l_press = 1'b1;
    if9.r_press = 1'b1;
    step(1);
    chk("s2_cancel", 32'(if9.lights), 32'h020);
    chk("s2_cancel_rw", 32'(if9.round_win), 32'd0);
    if9.l_press = 1'b0;
    if9.r_press = 1'b0;
    step(1);

    // Scenario 3: right wins a round, hold ignores pulls, recentres
    pulse_reset();
    tap9(1'b0, 32'h008, "s3_r1");
    tap9(1'b0, 32'h004, "s3_r2");
    tap9(1'b0, 32'h002, "s3_r3");
    tap9(1'b0, 32'h001, "s3_r4");
    if9.r_press = 1'b1;
    step(1);
    chk("s3_roundwin", 32'(if9.round_win), 32'd1);
    chk("s3_rscore",   32'(if9.r_score), 32'd1);
    chk("s3_winner",   32'(if9.winner), 32'(RIGHT));
    chk("s3_lights0",  32'(if9.lights), 32'h000);
    chk("s3_notover",  32'(if9.match_over), 32'd0);
    if9.r_press = 1'b0;
    step(1);
    chk("s3_pulse_end", 32'(if9.round_win), 32'd0);
    if9.l_press = 1'b1;
    step(1);
    if9.l_press = 1'b0;
    step(1);
    chk("s3_hold_dark", 32'(if9.lights), 32'h000);
    step(1);
    chk("s3_recentre", 32'(if9.lights), 32'h010);
    chk("s3_winner_clr", 32'(if9.winner), 32'(NONE));
    chk("s3_rscore_kept", 32'(if9.r_score), 32'd1);

    // Scenario 4: right takes rounds 2 and 3 -> match over
    tap9(1'b0, 32'h008, "s4a_r1");
    tap9(1'b0, 32'h004, "s4a_r2");
    tap9(1'b0, 32'h002, "s4a_r3");
    tap9(1'b0, 32'h001, "s4a_r4");
    tap9(1'b0, 32'h000, "s4a_win");
    step(3);
    chk("s4a_recentre", 32'(if9.lights), 32'h010);
    chk("s4a_rscore",   32'(if9.r_score), 32'd2);
    tap9(1'b0, 32'h008, "s4b_r1");
    tap9(1'b0, 32'h004, "s4b_r2");
    tap9(1'b0, 32'h002, "s4b_r3");
    tap9(1'b0, 32'h001, "s4b_r4");
    if9.r_press = 1'b1;
    step(1);
    chk("s4_matchover", 32'(if9.match_over), 32'd1);
    chk("s4_rscore3",   32'(if9.r_score), 32'd3);
    chk("s4_lights0",   32'(if9.lights), 32'h000);
    chk("s4_winner",    32'(if9.winner), 32'(RIGHT));
    if9.r_press = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if9.l_press = i[0];
      if9.r_press = ~i[0];
      step(2);
    end
    if9.l_press = 1'b0;
    if9.r_press = 1'b0;
    step(1);
    chk("s4_frozen_lights", 32'(if9.lights), 32'h000);
    chk("s4_frozen_rscore", 32'(if9.r_score), 32'd3);
    chk("s4_frozen_lscore", 32'(if9.l_score), 32'd0);
    chk("s4_frozen_over",   32'(if9.match_over), 32'd1);
    chk("s4_frozen_winner", 32'(if9.winner), 32'(RIGHT));
    reset = 1'b1;
    step(1);
    chk("s4_rst_lights", 32'(if9.lights), 32'h010);
    chk("s4_rst_rscore", 32'(if9.r_score), 32'd0);
    chk("s4_rst_over",   32'(if9.match_over), 32'd0);
    chk("s4_rst_winner", 32'(if9.winner), 32'(NONE));
    reset = 1'b0;
    step(1);

    // Scenario 5: press held through reset release; reset mid-hold
    if9.l_press = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    chk("s5_held_nomove", 32'(if9.lights), 32'h010);
    if9.l_press = 1'b0;
    step(1);
    chk("s5_release", 32'(if9.lights), 32'h010);
    if9.l_press = 1'b1;
    step(1);
    chk("s5_repress", 32'(if9.lights), 32'h020);
    if9.l_press = 1'b0;
    step(1);
    pulse_reset();
    tap9(1'b0, 32'h008, "s5_r1");
    tap9(1'b0, 32'h004, "s5_r2");
    tap9(1'b0, 32'h002, "s5_r3");
    tap9(1'b0, 32'h001, "s5_r4");
    tap9(1'b0, 32'h000, "s5_win");
    reset = 1'b1;
    step(1);
    chk("s5_midhold_lights", 32'(if9.lights), 32'h010);
    chk("s5_midhold_rscore", 32'(if9.r_score), 32'd0);
    chk("s5_midhold_winner", 32'(if9.winner), 32'(NONE));
    reset = 1'b0;
    step(1);
    tap9(1'b0, 32'h008, "s5_play_again");

    // Scenario 6: five-light field
    pulse_reset();
    chk("s6_rst_lights", 32'(if5.lights), 32'h04);
    tap5(1'b0, 32'h02, "s6_r1");
    tap5(1'b0, 32'h01, "s6_r2");
    if5.r_press = 1'b1;
    step(1);
    chk("s6_roundwin", 32'(if5.round_win), 32'd1);
    chk("s6_rscore",   32'(if5.r_score), 32'd1);
    chk("s6_winner",   32'(if5.winner), 32'(RIGHT));
    chk("s6_lights0",  32'(if5.lights), 32'h00);
    if5.r_press = 1'b0;
    step(1);
    step(3);
    chk("s6_recentre", 32'(if5.lights), 32'h04);
    chk("s6_winner_clr", 32'(if5.winner), 32'(NONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
